raster_bbox_scanner: RTL and testbench

//  Pixel-generation stage directly upstream of the barycentric-coordinate unit (bayesian_coord).
//  - Accepts one triangle with integer screen-space vertices.
//  - Clips the triangle's bounding box to the screen.
//  - Walks the box in raster order and presents one pixel per handshake.
//  - Each pixel carries the fp16 vertex set plus the fp16 pixel coordinate, i.e. the bayesian_coord input bundle.

---
 rtl/gpu_raster_pkg.sv | 20 ++
 rtl/int_to_half.sv | 28 ++
 rtl/raster_bbox_scanner.sv | 168 ++++++++++++++++
 tb/tb_raster_bbox_scanner.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_raster_pkg.sv
// Shared types and constants for the raster bounding-box scanner and its
// integer-to-fp16 converter.
package gpu_raster_pkg;

  localparam int FP16_W          = 16;
  localparam int COORD_W_DEFAULT = 11;

  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
  localparam logic [FP16_W-1:0] FP16_ONE  = 16'h3C00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CONV0,
    S_CONV1,
    S_CONV2,
    S_SCAN
  } state_t;

endpackage

// File: rtl/int_to_half.sv
// Exact unsigned integer to fp16 conversion for values up to 11 bits wide:
// priority-encode the msb, then shift the remaining bits into the mantissa.
module int_to_half
  import gpu_raster_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT
) (
  input  logic [COORD_W-1:0] val,
  output logic [FP16_W-1:0]  half
);

  logic [3:0]  msb;
  logic [10:0] ext;
  logic [10:0] aligned;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    msb = 4'd0;
    for (int i = 0; i < COORD_W; i++) begin
      if (val[i]) msb = 4'(i);
    end
    ext     = 11'(val);
    aligned = ext << (4'd10 - msb);
    half    = FP16_ZERO;
    if (val != '0) half = {1'b0, 5'd15 + 5'(msb), aligned[9:0]};
  end

endmodule

// File: rtl/raster_bbox_scanner.sv
// Accepts one integer triangle, clips its bounding box to the screen and walks
// it in raster order, emitting one fp16 pixel bundle per handshake.
module raster_bbox_scanner
  import gpu_raster_pkg::*;
#(
  parameter int COORD_W  = COORD_W_DEFAULT,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               nd,
  output logic               us_rfd,
  input  logic [COORD_W-1:0] v1_xi,
  input  logic [COORD_W-1:0] v1_yi,
  input  logic [COORD_W-1:0] v2_xi,
  input  logic [COORD_W-1:0] v2_yi,
  input  logic [COORD_W-1:0] v3_xi,
  input  logic [COORD_W-1:0] v3_yi,
  input  logic               ds_rfd,
  output logic               rdy,
  output logic [FP16_W-1:0]  v1_x,
  output logic [FP16_W-1:0]  v1_y,
  output logic [FP16_W-1:0]  v2_x,
  output logic [FP16_W-1:0]  v2_y,
  output logic [FP16_W-1:0]  v3_x,
  output logic [FP16_W-1:0]  v3_y,
  output logic [FP16_W-1:0]  p_x,
  output logic [FP16_W-1:0]  p_y,
  output logic [COORD_W-1:0] px_i,
  output logic [COORD_W-1:0] py_i,
  output logic               last,
  output logic               tri_skip
);

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H - 1);

  function automatic logic [COORD_W-1:0] min2(input logic [COORD_W-1:0] a, b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [COORD_W-1:0] max2(input logic [COORD_W-1:0] a, b);
    return (a > b) ? a : b;
  endfunction

  state_t state, state_next;

  logic [COORD_W-1:0] x1, y1, x2, y2, x3, y3;
  logic [COORD_W-1:0] xmin, xmax, ymin, ymax;
  logic [COORD_W-1:0] cx, cy;

  logic [COORD_W-1:0] bx_min, bx_max, by_min, by_max;
  logic               box_empty;
  logic [COORD_W-1:0] nx, ny;
  logic               at_end;
  logic               fire;
  logic [COORD_W-1:0] conv_a_in, conv_b_in;
  logic [FP16_W-1:0]  conv_a, conv_b;

  // Clipping applies to the box only; the vertex outputs keep the raw coordinates.
  assign bx_min    = min2(min2(x1, x2), x3);
  assign bx_max    = min2(max2(max2(x1, x2), x3), X_LIM);
  assign by_min    = min2(min2(y1, y2), y3);
  assign by_max    = min2(max2(max2(y1, y2), y3), Y_LIM);
  assign box_empty = (bx_min > bx_max) || (by_min > by_max);

  assign at_end = (cx == xmax) && (cy == ymax);
  assign nx     = (cx == xmax) ? xmin : cx + COORD_W'(1);
  assign ny     = (cx == xmax) ? cy + COORD_W'(1) : cy;
  assign fire   = rdy && ds_rfd;

  assign us_rfd = (state == S_IDLE);
  assign px_i   = cx;
  assign py_i   = cy;

  // Both converters are time-shared: first pixel in LOAD, one vertex per CONV
  // state, then the look-ahead pixel during SCAN.
  always_comb begin
    conv_a_in = '0;
    conv_b_in = '0;
    case (state)
      S_LOAD:  begin conv_a_in = bx_min; conv_b_in = by_min; end
      S_CONV0: begin conv_a_in = x1;     conv_b_in = y1;     end
      S_CONV1: begin conv_a_in = x2;     conv_b_in = y2;     end
      S_CONV2: begin conv_a_in = x3;     conv_b_in = y3;     end
      S_SCAN:  begin conv_a_in = nx;     conv_b_in = ny;     end
      default: ;
    endcase
  end

  int_to_half #(.COORD_W(COORD_W)) u_conv_a (.val(conv_a_in), .half(conv_a));
  int_to_half #(.COORD_W(COORD_W)) u_conv_b (.val(conv_b_in), .half(conv_b));

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (nd) state_next = S_LOAD;
      S_LOAD:  state_next = box_empty ? S_IDLE : S_CONV0;
      S_CONV0: state_next = S_CONV1;
      S_CONV1: state_next = S_CONV2;
      S_CONV2: state_next = S_SCAN;
      S_SCAN:  if (fire && at_end) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {x1, y1, x2, y2, x3, y3}             <= '0;
      {xmin, xmax, ymin, ymax}             <= '0;
      {cx, cy}                             <= '0;
      {v1_x, v1_y, v2_x, v2_y, v3_x, v3_y} <= '0;
      {p_x, p_y}                           <= '0;
      rdy                                  <= 1'b0;
      last                                 <= 1'b0;
      tri_skip                             <= 1'b0;
    end else begin
      tri_skip <= 1'b0;
      case (state)
        S_IDLE: if (nd) begin
          x1 <= v1_xi; y1 <= v1_yi;
          x2 <= v2_xi; y2 <= v2_yi;
          x3 <= v3_xi; y3 <= v3_yi;
        end
        S_LOAD: begin
          if (box_empty) begin
            tri_skip <= 1'b1;
          end else begin
            xmin <= bx_min; xmax <= bx_max;
            ymin <= by_min; ymax <= by_max;
            cx   <= bx_min; cy   <= by_min;
            p_x  <= conv_a; p_y  <= conv_b;
          end
        end
        S_CONV0: begin v1_x <= conv_a; v1_y <= conv_b; end
        S_CONV1: begin v2_x <= conv_a; v2_y <= conv_b; end
        S_CONV2: begin
          v3_x <= conv_a;
          v3_y <= conv_b;
          rdy  <= 1'b1;
          last <= at_end;
        end
        S_SCAN: if (fire) begin
          if (at_end) begin
            rdy  <= 1'b0;
            last <= 1'b0;
          end else begin
            cx   <= nx;
            cy   <= ny;
            p_x  <= conv_a;
            p_y  <= conv_b;
            last <= (nx == xmax) && (ny == ymax);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_raster_bbox_scanner.sv
// Self-checking bench: directed and random triangles scored against a raster
// walk of the clipped box, with randomised downstream back-pressure.
module tb_raster_bbox_scanner;
  import gpu_raster_pkg::*;

  localparam int CW = 11;
  localparam int SW = 640;
  localparam int SH = 480;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          nd = 1'b0;
  logic          ds_rfd = 1'b0;
  logic [CW-1:0] v1_xi = '0, v1_yi = '0, v2_xi = '0, v2_yi = '0, v3_xi = '0, v3_yi = '0;
  logic          us_rfd, rdy, last, tri_skip;
  logic [15:0]   v1_x, v1_y, v2_x, v2_y, v3_x, v3_y, p_x, p_y;
  logic [CW-1:0] px_i, py_i;

  raster_bbox_scanner #(.COORD_W(CW), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk(clk), .rst(rst), .nd(nd), .us_rfd(us_rfd),
    .v1_xi(v1_xi), .v1_yi(v1_yi), .v2_xi(v2_xi), .v2_yi(v2_yi),
    .v3_xi(v3_xi), .v3_yi(v3_yi),
    .ds_rfd(ds_rfd), .rdy(rdy),
    .v1_x(v1_x), .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y), .v3_x(v3_x), .v3_y(v3_y),
    .p_x(p_x), .p_y(p_y), .px_i(px_i), .py_i(py_i),
    .last(last), .tri_skip(tri_skip)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int exp_x[$];
  int exp_y[$];
  int tri_v[6];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // fp16 of a small non-negative integer, from its binary logarithm.
  function automatic logic [15:0] ref_half(input int v);
    int e;
    if (v == 0) return 16'h0000;
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    return 16'(((15 + e) << 10) + ((v * 1024) >> e) - 1024);
  endfunction

  function automatic int min3(input int a, b, c);
    int m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  function automatic int max3(input int a, b, c);
    int m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Called just after a falling edge while the DUT is idle.
  task automatic send_tri(input int ax, ay, bx, by, cx, cy);
    int xl, xh, yl, yh;
    tri_v = '{ax, ay, bx, by, cx, cy};
    exp_x.delete();
    exp_y.delete();
    xl = min3(ax, bx, cx);
    xh = max3(ax, bx, cx); if (xh > SW - 1) xh = SW - 1;
    yl = min3(ay, by, cy);
    yh = max3(ay, by, cy); if (yh > SH - 1) yh = SH - 1;
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++) begin
        exp_x.push_back(x);
        exp_y.push_back(y);
      end
    v1_xi = CW'(ax); v1_yi = CW'(ay);
    v2_xi = CW'(bx); v2_yi = CW'(by);
    v3_xi = CW'(cx); v3_yi = CW'(cy);
    check("us_rfd_before_nd", 32'(us_rfd), 32'd1);
    nd = 1'b1;
    @(negedge clk);
    nd = 1'b0;
    check("us_rfd_after_accept", 32'(us_rfd), 32'd0);
  endtask

  // mode 0: always ready; 1: random stalls; 2: three stall cycles on pixel 2.
  task automatic consume(input int mode);
    int npix, waited, cyc, idx, stalls;
    bit go;
    npix = exp_x.size();
    if (npix == 0) begin
      @(negedge clk);
      check("skip_pulse", 32'(tri_skip), 32'd1);
      check("skip_us_rfd", 32'(us_rfd), 32'd1);
      check("skip_no_rdy", 32'(rdy), 32'd0);
      repeat (6) begin
        @(negedge clk);
        check("skip_rdy_low", 32'(rdy), 32'd0);
      end
      check("skip_pulse_end", 32'(tri_skip), 32'd0);
      return;
    end
    waited = 0;
    while (!rdy && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check("rdy_rise", 32'(rdy), 32'd1);
    if (!rdy) return;
    check("v1_x", 32'(v1_x), 32'(ref_half(tri_v[0])));
    check("v1_y", 32'(v1_y), 32'(ref_half(tri_v[1])));
    check("v2_x", 32'(v2_x), 32'(ref_half(tri_v[2])));
    check("v2_y", 32'(v2_y), 32'(ref_half(tri_v[3])));
    check("v3_x", 32'(v3_x), 32'(ref_half(tri_v[4])));
    check("v3_y", 32'(v3_y), 32'(ref_half(tri_v[5])));
    cyc = 0; idx = 0; stalls = 0;
    while (exp_x.size() > 0 && cyc < 6000) begin
      check("rdy_held", 32'(rdy), 32'd1);
      check("px_i", 32'(px_i), 32'(exp_x[0]));
      check("py_i", 32'(py_i), 32'(exp_y[0]));
      check("p_x", 32'(p_x), 32'(ref_half(exp_x[0])));
      check("p_y", 32'(p_y), 32'(ref_half(exp_y[0])));
      check("last", 32'(last), 32'(exp_x.size() == 1));
      case (mode)
        1:       go = ($urandom_range(0, 2) != 0);
        2:       go = !(idx == 1 && stalls < 3);
        default: go = 1'b1;
      endcase
      if (!go) stalls++;
      ds_rfd = go;
      @(negedge clk);
      cyc++;
      if (go) begin
        void'(exp_x.pop_front());
        void'(exp_y.pop_front());
        idx++;
      end
    end
    check("pixel_count", 32'(idx), 32'(npix));
    check("cycle_count", 32'(cyc), 32'(npix + stalls));
    check("rdy_after_last", 32'(rdy), 32'd0);
    check("last_after_last", 32'(last), 32'd0);
    check("us_rfd_after_last", 32'(us_rfd), 32'd1);
    ds_rfd = 1'b1;
  endtask

  initial begin
    int waited;
    ds_rfd = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_us_rfd", 32'(us_rfd), 32'd1);
    check("rst_rdy", 32'(rdy), 32'd0);
    check("rst_last", 32'(last), 32'd0);
    check("rst_tri_skip", 32'(tri_skip), 32'd0);
    check("rst_p_x", 32'(p_x), 32'd0);
    check("rst_v1_x", 32'(v1_x), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Two-by-two box, full throughput then a stall on the second pixel.
    send_tri(0, 1, 0, 0, 1, 0);
    consume(0);
    send_tri(0, 1, 0, 0, 1, 0);
    consume(2);

    // Right-edge clipping: 40 x 3 pixels.
    send_tri(600, 0, 700, 0, 600, 2);
    consume(1);

    // Entirely off-screen in x.
    send_tri(640, 10, 700, 12, 650, 11);
    consume(0);

    // Vertex conversions 1023/2/3 and a clipped 638 x 2 box.
    send_tri(1023, 2, 2, 3, 3, 2);
    check("conv_1023", 32'(ref_half(1023)), 32'h63FE);
    consume(0);

    // Single pixel.
    send_tri(5, 5, 5, 5, 5, 5);
    consume(0);

    // Random small triangles, some past the screen edges.
    for (int t = 0; t < 25; t++) begin
      int bx, by;
      bx = $urandom_range(0, 700);
      by = $urandom_range(0, 520);
      send_tri(bx + $urandom_range(0, 6), by + $urandom_range(0, 6),
               bx + $urandom_range(0, 6), by + $urandom_range(0, 6),
               bx + $urandom_range(0, 6), by + $urandom_range(0, 6));
      consume(t % 2);
    end

    // Reset in the middle of a scan, then a triangle on the first edge after release.
    send_tri(0, 0, 9, 0, 0, 9);
    waited = 0;
    while (!rdy && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_rdy", 32'(rdy), 32'd0);
    check("midrst_last", 32'(last), 32'd0);
    check("midrst_us_rfd", 32'(us_rfd), 32'd1);
    check("midrst_p_x", 32'(p_x), 32'd0);
    check("midrst_px_i", 32'(px_i), 32'd0);
    check("midrst_v1_x", 32'(v1_x), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    send_tri(3, 4, 6, 4, 3, 5);
    consume(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
